// File: rtl/score_keeper.sv
// Two-player score keeper: counts point edges, detects the win, flashes the
// winner's score for a fixed number of toggles, then holds it until a new game.
module score_keeper #(
   parameter int WIN_SCORE   = 9,
   parameter int FLASH_DIV   = 25000000,
   parameter int FLASH_COUNT = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       point_left,
   input  logic       point_right,
   input  logic       new_game,
   output logic [7:0] count,
   output logic       serve_ok,
   output logic       game_over,
   output logic       winner
);

   localparam int DIV_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
   localparam int TOG_W = $clog2(FLASH_COUNT + 1);

   localparam logic [3:0]       WIN      = 4'(WIN_SCORE);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FLASH_DIV - 1);
   localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(FLASH_COUNT - 1);

   typedef enum logic [1:0] {PLAY, WIN_FLASH, WIN_HOLD} state_t;

   state_t           state, state_nxt;
   logic [3:0]       score_l, score_r, score_l_nxt, score_r_nxt;
   logic [3:0]       score_l_inc, score_r_inc;
   logic             prev_l, prev_r;
   logic             edge_l, edge_r;
   logic [DIV_W-1:0] div_cnt, div_nxt;
   logic [TOG_W-1:0] tog_cnt, tog_nxt;
   logic             blank, blank_nxt;
   logic             winner_q, winner_nxt;

   assign edge_l      = point_left  & ~prev_l;
   assign edge_r      = point_right & ~prev_r;
   assign score_l_inc = score_l + 4'd1;
   assign score_r_inc = score_r + 4'd1;

   // State register; prev_x tracks the inputs every cycle regardless of state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= PLAY;
         score_l  <= '0;
         score_r  <= '0;
         prev_l   <= 1'b1;
         prev_r   <= 1'b1;
         div_cnt  <= '0;
         tog_cnt  <= '0;
         blank    <= 1'b0;
         winner_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         score_l  <= score_l_nxt;
         score_r  <= score_r_nxt;
         prev_l   <= point_left;
         prev_r   <= point_right;
         div_cnt  <= div_nxt;
         tog_cnt  <= tog_nxt;
         blank    <= blank_nxt;
         winner_q <= winner_nxt;
      end
   end

   // Next-state: scoring in PLAY, flash timing in WIN_FLASH; new_game overrides all.
   always_comb begin
      state_nxt   = state;
      score_l_nxt = score_l;
      score_r_nxt = score_r;
      div_nxt     = div_cnt;
      tog_nxt     = tog_cnt;
      blank_nxt   = blank;
      winner_nxt  = winner_q;
      case (state)
         PLAY: begin
            // Simultaneous edges are ambiguous and deliberately dropped.
            if (edge_l && !edge_r) begin
               score_l_nxt = score_l_inc;
               if (score_l_inc == WIN) begin
                  state_nxt  = WIN_FLASH;
                  winner_nxt = 1'b0;
                  div_nxt    = '0;
                  tog_nxt    = '0;
                  blank_nxt  = 1'b0;
               end
            end else if (edge_r && !edge_l) begin
               score_r_nxt = score_r_inc;
               if (score_r_inc == WIN) begin
                  state_nxt  = WIN_FLASH;
                  winner_nxt = 1'b1;
                  div_nxt    = '0;
                  tog_nxt    = '0;
                  blank_nxt  = 1'b0;
               end
            end
         end
         WIN_FLASH: begin
            if (div_cnt == DIV_LAST) begin
               div_nxt   = '0;
               blank_nxt = ~blank;
               tog_nxt   = tog_cnt + TOG_W'(1);
               if (tog_cnt == TOG_LAST) begin
                  state_nxt = WIN_HOLD;
                  blank_nxt = 1'b0;
               end
            end else begin
               div_nxt = div_cnt + DIV_W'(1);
            end
         end
         WIN_HOLD: ;
         default: state_nxt = PLAY;
      endcase
      if (new_game) begin
         state_nxt   = PLAY;
         score_l_nxt = '0;
         score_r_nxt = '0;
         div_nxt     = '0;
         tog_nxt     = '0;
         blank_nxt   = 1'b0;
      end
   end

   // Outputs are pure decodes of registered state; blank is only ever set in WIN_FLASH.
   always_comb begin
      count = {score_r, score_l};
      if (blank) begin
         if (winner_q) count[7:4] = 4'd0;
         else          count[3:0] = 4'd0;
      end
      serve_ok  = (state == PLAY);
      game_over = (state != PLAY);
      winner    = winner_q;
   end

endmodule

// File: tb/tb_score_keeper.sv
// Randomized + directed bench for score_keeper; a cycle-level reference model
// pushes expected outputs, a separate monitor pops and compares them.
module tb_score_keeper;

   localparam int WS = 3;
   localparam int FD = 4;
   localparam int FC = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       point_left = 1'b0;
   logic       point_right = 1'b0;
   logic       new_game = 1'b0;
   logic [7:0] count;
   logic       serve_ok, game_over, winner;

   score_keeper #(.WIN_SCORE(WS), .FLASH_DIV(FD), .FLASH_COUNT(FC)) dut (
      .clk(clk), .rst(rst), .point_left(point_left), .point_right(point_right),
      .new_game(new_game), .count(count), .serve_ok(serve_ok),
      .game_over(game_over), .winner(winner)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] count;
      logic       serve_ok;
      logic       game_over;
      logic       winner;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   // Reference model: game is either live or over; after the win the display
   // pattern is derived purely from the number of cycles elapsed since the win.
   int m_l, m_r, m_over, m_win, m_k, m_pl, m_pr;

   function automatic exp_t model_out();
      exp_t e;
      int   toggles;
      int   show_l, show_r;
      show_l = m_l;
      show_r = m_r;
      if (m_over != 0) begin
         toggles = m_k / FD;
         if (toggles < FC && (toggles % 2) == 1) begin
            if (m_win != 0) show_r = 0;
            else            show_l = 0;
         end
      end
      e.count     = 8'((show_r << 4) | show_l);
      e.serve_ok  = (m_over == 0);
      e.game_over = (m_over != 0);
      e.winner    = m_win[0];
      return e;
   endfunction

   task automatic model_step(input logic r, input logic ng, input logic pl, input logic pr);
      int el, er;
      if (r) begin
         m_l = 0; m_r = 0; m_over = 0; m_win = 0; m_k = 0; m_pl = 1; m_pr = 1;
      end else begin
         el = (pl && m_pl == 0) ? 1 : 0;
         er = (pr && m_pr == 0) ? 1 : 0;
         if (m_over != 0 && m_k < 1000000) m_k++;
         if (ng) begin
            m_l = 0; m_r = 0; m_over = 0; m_k = 0;
         end else if (m_over == 0 && (el + er) == 1) begin
            if (el == 1) m_l++; else m_r++;
            if (m_l == WS || m_r == WS) begin
               m_over = 1; m_win = (m_r == WS) ? 1 : 0; m_k = 0;
            end
         end
         m_pl = pl ? 1 : 0;
         m_pr = pr ? 1 : 0;
      end
   endtask

   // One clock of stimulus: drive on the falling edge, queue the expected result.
   task automatic step(input logic r, input logic ng, input logic pl, input logic pr);
      @(negedge clk);
      rst = r; new_game = ng; point_left = pl; point_right = pr;
      model_step(r, ng, pl, pr);
      exp_q.push_back(model_out());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pulse(input logic l, input logic r);
      step(1'b0, 1'b0, l, r);
      step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Monitor: every registered output update is compared against the queue head.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (count !== e.count) begin
               failures++;
               $display("FAIL count t=%0t got=%h exp=%h", $time, count, e.count);
            end
            checks++;
            if (serve_ok !== e.serve_ok) begin
               failures++;
               $display("FAIL serve_ok t=%0t got=%b exp=%b", $time, serve_ok, e.serve_ok);
            end
            checks++;
            if (game_over !== e.game_over) begin
               failures++;
               $display("FAIL game_over t=%0t got=%b exp=%b", $time, game_over, e.game_over);
            end
            if (e.game_over) begin
               checks++;
               if (winner !== e.winner) begin
                  failures++;
                  $display("FAIL winner t=%0t got=%b exp=%b", $time, winner, e.winner);
               end
            end
         end
      end
   end

   initial begin
      logic r, ng, pl, pr;
      int   wait_cnt;
      // reset state, then 2 left + 1 right -> 8'h12
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      idle(2);
      // held-high input scores once
      step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
      idle(2);
      // simultaneous rise ignored
      step(1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      idle(2);
      // left wins 3-1, full flash sequence, points ignored while over
      step(1'b0, 1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1);
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++) pulse(i[0], ~i[0]);
      idle(6);
      // new_game during hold with a point edge in the same cycle
      step(1'b0, 1'b1, 1'b1, 1'b0);
      idle(2);
      // right wins 0-3, reset mid-flash with point_right held through release
      pulse(1'b0, 1'b1);
      pulse(1'b0, 1'b1);
      pulse(1'b0, 1'b1);
      idle(5);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      pulse(1'b0, 1'b1);
      idle(2);
      // randomized play
      pl = 1'b0; pr = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 2) == 0) pl = ~pl;
         if ($urandom_range(0, 2) == 0) pr = ~pr;
         ng = ($urandom_range(0, 59) == 0);
         r  = ($urandom_range(0, 249) == 0);
         step(r, ng, pl, pr);
      end
      idle(1);
      // drain: bounded wait for the monitor to consume every expectation
      wait_cnt = 0;
      while (exp_q.size() > 0 && wait_cnt < 20) begin
         @(negedge clk);
         wait_cnt++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain left=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
